// File: rtl/bj_pkg.sv
// Shared types, constants and helpers for the blackjack card dealer.
// Provides the dealer FSM state enum, rank/deck constants and the
// rank-to-blackjack-value mapping used by the dealer and the scoring logic.
package bj_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2,
      SHUF = 2'd3
   } state_t;

   localparam int unsigned RANK_ACE       = 1;
   localparam int unsigned RANK_KING      = 13;
   localparam int unsigned CARDS_PER_DECK = 52;

   // Blackjack value of a rank: ace counts 11, face cards 10, pips face value.
   function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
      if (rank == 4'(RANK_ACE)) begin
         return 4'd11;
      end else if (rank > 4'd10) begin
         return 4'd10;
      end else begin
         return rank;
      end
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with synchronous seed load.
// Ports:
//   CLOCK_50  in   clock, rising edge
//   reset     in   synchronous active-high reset, loads SEED
//   load      in   load load_val this cycle instead of advancing
//   load_val  in   seed value; zero is replaced by SEED (zero locks the LFSR)
//   q         out  current LFSR state
module lfsr_galois #(
   parameter int unsigned     W    = 16,
   parameter logic [W-1:0]    TAPS = W'(16'hB400),
   parameter logic [W-1:0]    SEED = W'(16'hACE1)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   output logic [W-1:0]  q
);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         q <= SEED;
      end else if (load) begin
         q <= (load_val == '0) ? SEED : load_val;
      end else if (q[0]) begin
         q <= (q >> 1) ^ TAPS;
      end else begin
         q <= q >> 1;
      end
   end

endmodule

// File: rtl/card_shoe_rng.sv
// Random blackjack card dealer drawing without replacement from a shoe of
// DECKS decks. A free-running LFSR is rejection-sampled: a 4-bit sample is
// accepted only if it is a legal rank with copies left in the shoe.
// Ports:
//   CLOCK_50    in   clock, rising edge
//   reset       in   synchronous active-high reset (full shoe, IDLE)
//   seed_load   in   load seed_in into the LFSR this cycle
//   seed_in     in   LFSR seed (0 selects SEED)
//   shuffle     in   refill request, wins over a simultaneous req
//   req         in   draw request, taken when ready and shoe not empty
//   ready       out  dealer idle
//   card_valid  out  one-cycle pulse with a new card
//   card_rank   out  rank 1..13, held until the next draw
//   card_value  out  blackjack value of card_rank
//   cards_left  out  cards remaining in the shoe
//   shoe_empty  out  cards_left == 0 (combinational)
module card_shoe_rng
   import bj_pkg::*;
#(
   parameter int unsigned          LFSR_W = 16,
   parameter logic [LFSR_W-1:0]    TAPS   = LFSR_W'(16'hB400),
   parameter logic [LFSR_W-1:0]    SEED   = LFSR_W'(16'hACE1),
   parameter int unsigned          DECKS  = 1
) (
   input  logic                              CLOCK_50,
   input  logic                              reset,
   input  logic                              seed_load,
   input  logic [LFSR_W-1:0]                 seed_in,
   input  logic                              shuffle,
   input  logic                              req,
   output logic                              ready,
   output logic                              card_valid,
   output logic [3:0]                        card_rank,
   output logic [3:0]                        card_value,
   output logic [$clog2(52*DECKS+1)-1:0]     cards_left,
   output logic                              shoe_empty
);

   localparam int unsigned CW = $clog2(4*DECKS+1);
   localparam int unsigned CL = $clog2(CARDS_PER_DECK*DECKS+1);
   localparam logic [CW-1:0] FULL_RANK = CW'(4*DECKS);
   localparam logic [CL-1:0] FULL_SHOE = CL'(CARDS_PER_DECK*DECKS);

   state_t              state;
   logic [3:0]          shuf_idx;
   logic [CW-1:0]       count [0:15];
   logic [LFSR_W-1:0]   lfsr;
   logic [3:0]          s;
   logic                hit;

   lfsr_galois #(
      .W    (LFSR_W),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .load     (seed_load),
      .load_val (seed_in),
      .q        (lfsr)
   );

   // Only the low nibble is sampled; the rest of the state just feeds the sequence.
   generate
      if (LFSR_W > 4) begin : g_unused
         logic unused_lfsr_hi;
         assign unused_lfsr_hi = ^lfsr[LFSR_W-1:4];
      end
   endgenerate

   // Sample is a legal rank that still has copies in the shoe.
   assign s          = lfsr[3:0];
   assign hit        = (s >= 4'(RANK_ACE)) && (s <= 4'(RANK_KING)) && (count[s] != '0);
   assign shoe_empty = (cards_left == '0);

   // Dealer FSM, rank counters and registered outputs.
   // Entries 0, 14 and 15 of count are never refilled; they are unreachable
   // because hit rejects those samples before the count is consulted.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= IDLE;
         ready      <= 1'b1;
         card_valid <= 1'b0;
         card_rank  <= 4'd0;
         card_value <= 4'd0;
         cards_left <= FULL_SHOE;
         shuf_idx   <= 4'(RANK_ACE);
         for (int i = 0; i < 16; i++) begin
            count[i] <= FULL_RANK;
         end
      end else begin
         card_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (shuffle) begin
                  state    <= SHUF;
                  ready    <= 1'b0;
                  shuf_idx <= 4'(RANK_ACE);
               end else if (req && !shoe_empty) begin
                  state <= DRAW;
                  ready <= 1'b0;
               end
            end
            DRAW: begin
               if (hit) begin
                  count[s]   <= count[s] - CW'(1);
                  cards_left <= cards_left - CL'(1);
                  card_rank  <= s;
                  card_value <= rank_to_value(s);
                  card_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               ready <= 1'b1;
               state <= IDLE;
            end
            SHUF: begin
               count[shuf_idx] <= FULL_RANK;
               if (shuf_idx == 4'(RANK_KING)) begin
                  cards_left <= FULL_SHOE;
                  ready      <= 1'b1;
                  state      <= IDLE;
               end else begin
                  shuf_idx <= shuf_idx + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_shoe_rng.sv
// Directed self-checking bench for card_shoe_rng (default parameters,
// one deck). A small LFSR/shoe model predicts every drawn card.
module tb_card_shoe_rng;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = 16'h0;
   logic        shuffle = 1'b0;
   logic        req = 1'b0;
   logic        ready;
   logic        card_valid;
   logic [3:0]  card_rank;
   logic [3:0]  card_value;
   logic [5:0]  cards_left;
   logic        shoe_empty;

   int checks = 0;
   int passed = 0;

   logic [15:0] m_lfsr;
   int          m_count [1:13];
   int          tally   [1:13];

   always #5 clk = ~clk;

   card_shoe_rng dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .shuffle    (shuffle),
      .req        (req),
      .ready      (ready),
      .card_valid (card_valid),
      .card_rank  (card_rank),
      .card_value (card_value),
      .cards_left (cards_left),
      .shoe_empty (shoe_empty)
   );

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [3:0] exp_value(input int r);
      if (r == 1) return 4'd11;
      if (r >= 11) return 4'd10;
      return 4'(r);
   endfunction

   // Reference LFSR, stepping on the same edges as the design.
   always @(posedge clk) begin
      if (reset) m_lfsr <= 16'hACE1;
      else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
      else m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic model_full();
      for (int i = 1; i <= 13; i++) m_count[i] = 4;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
      model_full();
   endtask

   // Called at a negedge in IDLE; returns at a negedge.
   task automatic do_draw(output int rank_out);
      logic [15:0] v;
      logic [3:0]  smp;
      logic [5:0]  left_before;
      logic        early;
      int          k;
      int          r;
      left_before = cards_left;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      v = m_lfsr;
      r = 0;
      k = -1;
      for (int j = 0; j < 70000; j++) begin
         smp = v[3:0];
         if (smp >= 4'd1 && smp <= 4'd13 && m_count[smp] > 0) begin
            r = int'(smp);
            k = j;
            break;
         end
         v = lfsr_step(v);
      end
      rank_out = r;
      checks++;
      if (k < 0 || ready !== 1'b0) begin
         $display("FAIL draw_start: ready=%b predicted_rejects=%0d, required ready=0 and a reachable card", ready, k);
         @(negedge clk);
         return;
      end
      passed++;
      early = 1'b0;
      for (int n = 0; n < k; n++) begin
         @(posedge clk); #1;
         if (card_valid !== 1'b0) early = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (card_valid !== 1'b1 || early) $display("FAIL valid_timing: card_valid=%b early=%b after %0d rejects, required 1 and no early pulse", card_valid, early, k);
      else passed++;
      checks++;
      if (card_rank !== 4'(r)) $display("FAIL card_rank: got %0d, required %0d", card_rank, r);
      else passed++;
      checks++;
      if (card_value !== exp_value(r)) $display("FAIL card_value: rank %0d got %0d, required %0d", r, card_value, exp_value(r));
      else passed++;
      checks++;
      if (cards_left !== left_before - 6'd1) $display("FAIL cards_left_dec: got %0d, required %0d", cards_left, left_before - 6'd1);
      else passed++;
      m_count[r] = m_count[r] - 1;
      tally[r] = tally[r] + 1;
      @(posedge clk); #1;
      checks++;
      if (card_valid !== 1'b0 || ready !== 1'b1) $display("FAIL ready_after: card_valid=%b ready=%b, required 0/1", card_valid, ready);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || card_valid !== 1'b0) $display("FAIL reset_ctl: ready=%b card_valid=%b, required 1/0", ready, card_valid);
      else passed++;
      checks++;
      if (cards_left !== 6'd52 || shoe_empty !== 1'b0) $display("FAIL reset_shoe: cards_left=%0d shoe_empty=%b, required 52/0", cards_left, shoe_empty);
      else passed++;
      checks++;
      if (card_rank !== 4'd0 || card_value !== 4'd0) $display("FAIL reset_card: rank=%0d value=%0d, required 0/0", card_rank, card_value);
      else passed++;
      checks++;
      if (dut.u_lfsr.q !== 16'hACE1) $display("FAIL reset_lfsr: got %h, required ace1", dut.u_lfsr.q);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      model_full();
   endtask

   task automatic test_seeded_draw();
      int r;
      seed_in = 16'h0003;
      seed_load = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.u_lfsr.q !== 16'h0003) $display("FAIL seed_load: got %h, required 0003", dut.u_lfsr.q);
      else passed++;
      @(negedge clk);
      seed_load = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (dut.u_lfsr.q !== 16'hB401) $display("FAIL lfsr_step: got %h, required b401", dut.u_lfsr.q);
      else passed++;
      @(negedge clk);
      seed_in = 16'h0000;
      seed_load = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.u_lfsr.q !== 16'hACE1) $display("FAIL seed_zero: got %h, required ace1", dut.u_lfsr.q);
      else passed++;
      @(negedge clk);
      seed_load = 1'b0;
      // ace1 -> e270 (sample 0, rejected) -> 7138 (sample 8, accepted)
      do_draw(r);
      checks++;
      if (r != 8 || card_rank !== 4'd8 || card_value !== 4'd8) $display("FAIL seeded_card: rank=%0d value=%0d, required 8/8", card_rank, card_value);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int r;
      do_reset();
      for (int i = 1; i <= 13; i++) tally[i] = 0;
      for (int i = 0; i < 52; i++) do_draw(r);
      for (int i = 1; i <= 13; i++) begin
         checks++;
         if (tally[i] != 4) $display("FAIL rank_tally: rank %0d drawn %0d times, required 4", i, tally[i]);
         else passed++;
      end
      checks++;
      if (cards_left !== 6'd0 || shoe_empty !== 1'b1) $display("FAIL exhausted: cards_left=%0d shoe_empty=%b, required 0/1", cards_left, shoe_empty);
      else passed++;
      req = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         checks++;
         if (card_valid !== 1'b0 || ready !== 1'b1) $display("FAIL empty_req: cycle %0d card_valid=%b ready=%b, required 0/1", n, card_valid, ready);
         else passed++;
      end
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic test_shuffle();
      int r;
      shuffle = 1'b1;
      @(posedge clk); #1;
      shuffle = 1'b0;
      for (int n = 0; n < 13; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         checks++;
         if (ready !== 1'b0) $display("FAIL shuf_busy: cycle %0d ready=%b, required 0", n, ready);
         else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || cards_left !== 6'd52 || shoe_empty !== 1'b0) $display("FAIL shuf_done: ready=%b cards_left=%0d shoe_empty=%b, required 1/52/0", ready, cards_left, shoe_empty);
      else passed++;
      model_full();
      @(negedge clk);
      do_draw(r);
   endtask

   task automatic test_shuffle_req();
      logic [5:0] left_before;
      left_before = cards_left;
      shuffle = 1'b1;
      req = 1'b1;
      @(posedge clk); #1;
      shuffle = 1'b0;
      req = 1'b0;
      for (int n = 0; n < 13; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         checks++;
         if (ready !== 1'b0 || card_valid !== 1'b0 || cards_left !== left_before) $display("FAIL shuf_req: cycle %0d ready=%b card_valid=%b cards_left=%0d, required 0/0/%0d", n, ready, card_valid, cards_left, left_before);
         else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || cards_left !== 6'd52 || card_valid !== 1'b0) $display("FAIL shuf_req_done: ready=%b cards_left=%0d card_valid=%b, required 1/52/0", ready, cards_left, card_valid);
      else passed++;
      model_full();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic seen;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      checks++;
      if (ready !== 1'b0) $display("FAIL mid_draw_entry: ready=%b, required 0", ready);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || card_valid !== 1'b0 || cards_left !== 6'd52) $display("FAIL reset_in_draw: ready=%b card_valid=%b cards_left=%0d, required 1/0/52", ready, card_valid, cards_left);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      model_full();
      seen = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (card_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) $display("FAIL stale_card: card_valid pulsed after reset, required none");
      else passed++;
      @(negedge clk);
      shuffle = 1'b1;
      @(posedge clk); #1;
      shuffle = 1'b0;
      for (int n = 0; n < 5; n++) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || cards_left !== 6'd52 || shoe_empty !== 1'b0) $display("FAIL reset_in_shuf: ready=%b cards_left=%0d shoe_empty=%b, required 1/52/0", ready, cards_left, shoe_empty);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      model_full();
   endtask

   initial begin
      int r;
      @(negedge clk);
      test_reset();
      test_seeded_draw();
      test_back_to_back();
      test_shuffle();
      test_shuffle_req();
      test_reset_mid();
      do_draw(r);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/card_shoe_rng.md
# card_shoe_rng

Parametrised random card dealer that succeeds the fixed 5-bit number generator. It draws blackjack cards without replacement from a shoe of `DECKS` standard decks, using a free-running Galois LFSR and rejection sampling. It sits between the game FSM (which issues draw requests) and the scoring and 7-segment display logic (which consume rank and value).

## Interface
Parameters:
- `LFSR_W`, 16: LFSR width; must be ≥ 4.
- `TAPS`, 16'hB400: Galois tap mask; must give a maximal-length sequence.
- `SEED`, 16'hACE1: LFSR value at reset, and substitute for any zero seed.
- `DECKS`, 1: number of 52-card decks in the shoe (1..8).

Ports:
- `CLOCK_50` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `seed_load` in 1: when high, load `seed_in` into the LFSR.
- `seed_in` in `LFSR_W`: seed value.
- `shuffle` in 1: one-cycle request to refill the shoe.
- `req` in 1: draw request; accepted only when `ready` is high and `shoe_empty` is low.
- `ready` out 1: high in IDLE.
- `card_valid` out 1: one-cycle pulse when a card is delivered.
- `card_rank` out 4: card rank 1..13 (1 = A, 11..13 = J/Q/K).
- `card_value` out 4: card value; A = 11, J/Q/K = 10, otherwise equal to rank.
- `cards_left` out `$clog2(52*DECKS+1)`: cards remaining in the shoe.
- `shoe_empty` out 1: high when `cards_left` is 0.

## Operation
- **LFSR**
  - Advances every cycle regardless of FSM state, so button timing adds entropy.
  - Update rule: if `lfsr[0]` is 1, `lfsr <= (lfsr>>1) ^ TAPS`; otherwise `lfsr <= lfsr>>1`.
  - `seed_load` overrides the advance for that cycle. A `seed_in` of 0 loads `SEED` instead.
- **Rank counters**: 13 counters, each `$clog2(4*DECKS+1)` bits wide, each holding the remaining copies of one rank.
- **FSM states**:
  - IDLE
    - `ready` is 1.
    - `shuffle` moves to SHUF. `shuffle` has priority over a simultaneous `req`, and that `req` is dropped.
    - `req` with `!shoe_empty` moves to DRAW.
    - `req` with `shoe_empty` is ignored.
  - DRAW
    - Samples `s = lfsr[3:0]` each cycle.
    - Accept when `s` is in 1..13 and `count[s]` is not 0.
    - On accept:
      - decrement `count[s]`, `cards_left`;
      - register `card_rank <= s` and `card_value <= map(s)`;
      - move to DONE.
    - Otherwise stay in DRAW and resample next cycle.
    - Termination is guaranteed within 2^LFSR_W − 1 cycles because every nonzero LFSR state is visited.
  - DONE
    - `card_valid` is 1 for this cycle only.
    - Next state is IDLE.
  - SHUF
    - Writes `count[i] <= 4*DECKS` for i = 1..13, one rank per cycle: 13 cycles.
    - Then `cards_left <= 52*DECKS`, and next state is IDLE.
    - `req` is ignored throughout.
- **Held outputs**: `card_rank` and `card_value` hold their value until the next accepted draw.
- **`shoe_empty`**: combinational, equal to (`cards_left == 0`).

## Timing
- **Reset values**
  - State IDLE; `ready` = 1; `card_valid` = 0.
  - `card_rank` = 0; `card_value` = 0.
  - All counts = `4*DECKS`; `cards_left` = `52*DECKS`; `shoe_empty` = 0.
  - LFSR = `SEED`.
- **Reset mid-operation**: reset in any state (DRAW, SHUF, DONE) applies the values above on the next edge. A pending card is not delivered.
- **Draw latency**
  - `req` accepted at edge t, so DRAW is active from t+1.
  - Best-case `card_valid` at t+2; add one cycle per rejected sample.
  - `ready` is low from t+1 through the DONE cycle and high again the cycle after `card_valid`.
- **Counter timing**: `cards_left` and the rank counter update on the accept edge and are visible in the same cycle as `card_valid`.
- **Shuffle timing**: `shuffle` accepted at t gives `ready` low for cycles t+1..t+13 and `ready` high at t+14 with a full shoe.
- **Seed timing**: `seed_load` at t gives LFSR = `seed_in` (or `SEED`) at t+1. Loading during DRAW is allowed and affects the next sample.

## Structure
- **Package `bj_pkg`**
  - State enum (IDLE, DRAW, DONE, SHUF).
  - Constants `RANK_ACE` = 1, `RANK_KING` = 13, `CARDS_PER_DECK` = 52.
  - Function `rank_to_value(rank)`.
- **Sub-module `lfsr_galois`**: parameters `W`, `TAPS`, `SEED`; ports `CLOCK_50`, `reset`, `load`, `load_val`, `q`.
- **Display**: the existing `char_7seg` decoding stays outside this block.

## Test plan
- **Reset**: pulse `reset` for 1 cycle. Expect `ready` = 1, `cards_left` = 52, `shoe_empty` = 0, `card_valid` = 0, `card_rank` = 0.
- **Seeded draw**:
  - Apply `seed_load`=1 with `seed_in`=0, then `req`.
  - Expect LFSR = 16'hACE1 on the load cycle + 1.
  - `card_rank` must match the bit-accurate reference model.
  - Check `card_value` mapping: rank 1 → 11, rank 12 → 10, rank 7 → 7.
- **Exhaustion** (`DECKS`=1):
  - Issue 52 back-to-back draws. Expect each rank exactly 4 times, `cards_left` = 0, `shoe_empty` = 1.
  - A 53rd `req` gives no `card_valid` over 200 cycles, with `ready` staying at 1.
- **Shuffle**: pulse `shuffle` when empty. Expect `ready` = 0 for 13 cycles, then `cards_left` = 52 and `shoe_empty` = 0; the next `req` delivers a card.
- **Shuffle and req together**: assert both in IDLE. Expect SHUF entered, no `card_valid`, and `cards_left` unchanged until SHUF completes.
- **Reset mid-draw**: assert `reset` while in DRAW or SHUF. Next cycle: `ready` = 1, `card_valid` never pulses, `cards_left` = 52.
